// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB register and writeback stage: default widths,
// writeback source encoding, the latched MEM/WB record and the writeback mux.
package wb_pkg;

    localparam int WB_DATA_W    = 16;
    localparam int WB_REG_SEL_W = 3;
    localparam int WB_CNT_W     = 16;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_IMM  = 2'b11
    } wb_src_e;

    // Everything the MEM/WB register captures from the MEM stage.
    typedef struct packed {
        logic                    valid;
        logic                    reg_wr;
        logic [WB_REG_SEL_W-1:0] wr_sel;
        wb_src_e                 wb_src;
        logic [WB_DATA_W-1:0]    alu_res;
        logic [WB_DATA_W-1:0]    rd_data;
        logic [WB_DATA_W-1:0]    pc_inc;
        logic [WB_DATA_W-1:0]    imm;
        logic                    halt;
        logic                    err;
    } memwb_t;

    // Writeback data select; the default arm keeps the output defined for any code.
    function automatic logic [WB_DATA_W-1:0] wb_select(
        input wb_src_e              src,
        input logic [WB_DATA_W-1:0] alu_res,
        input logic [WB_DATA_W-1:0] rd_data,
        input logic [WB_DATA_W-1:0] pc_inc,
        input logic [WB_DATA_W-1:0] imm
    );
        logic [WB_DATA_W-1:0] sel;
        case (src)
            WB_ALU:  sel = alu_res;
            WB_MEM:  sel = rd_data;
            WB_LINK: sel = pc_inc;
            WB_IMM:  sel = imm;
            default: sel = alu_res;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_retire_ctr.sv
// Saturating retired-instruction counter: synchronous clear, count enable,
// and a freeze input that blocks counting once the processor has halted.
module wb_retire_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    // Count up by one per enabled edge, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && !freeze && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register plus writeback stage. Drives the register-file
// write port, holds sticky halt/error status and counts retired instructions.
// Optional feature macro: WB_FWD_EN adds a one-entry register of the previous
// cycle's committed write (fwd_valid/fwd_sel/fwd_data) for late EX forwarding.
// The latched record uses the widths from wb_pkg; the parameters default to them.
module memwb_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int REG_SEL_W = WB_REG_SEL_W,
    parameter int CNT_W     = WB_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_reg_wr,
    input  logic [REG_SEL_W-1:0] mem_wr_sel,
    input  logic [1:0]           mem_wb_src,
    input  logic [DATA_W-1:0]    mem_alu_res,
    input  logic [DATA_W-1:0]    mem_rd_data,
    input  logic [DATA_W-1:0]    mem_pc_inc,
    input  logic [DATA_W-1:0]    mem_imm,
    input  logic                 mem_halt,
    input  logic                 mem_err,
    output logic [REG_SEL_W-1:0] writeRegSel,
    output logic [DATA_W-1:0]    writeData,
    output logic                 writeEn,
    output logic                 halt,
    output logic                 err,
    output logic [CNT_W-1:0]     retired
`ifdef WB_FWD_EN
    ,
    output logic                 fwd_valid,
    output logic [REG_SEL_W-1:0] fwd_sel,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    memwb_t memwb_p0;
    memwb_t memwb_p1;
    logic   vld_p1;
    logic   halt_hit;
    logic   retire_en;
    logic   halt_q;
    logic   err_q;

    // Gather the MEM-stage inputs into one record for the pipeline register.
    always_comb begin
        memwb_p0         = '0;
        memwb_p0.valid   = mem_valid;
        memwb_p0.reg_wr  = mem_reg_wr;
        memwb_p0.wr_sel  = mem_wr_sel;
        memwb_p0.wb_src  = wb_src_e'(mem_wb_src);
        memwb_p0.alu_res = mem_alu_res;
        memwb_p0.rd_data = mem_rd_data;
        memwb_p0.pc_inc  = mem_pc_inc;
        memwb_p0.imm     = mem_imm;
        memwb_p0.halt    = mem_halt;
        memwb_p0.err     = mem_err;
    end

    // ---- MEM -> WB boundary ----
    // Pipeline register: reset clears everything, flush inserts a bubble (data left as is),
    // stall holds, otherwise capture the MEM stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_p1 <= '0;
        end else if (flush) begin
            memwb_p1.valid  <= 1'b0;
            memwb_p1.reg_wr <= 1'b0;
        end else if (!stall) begin
            memwb_p1 <= memwb_p0;
        end
    end

    assign vld_p1   = memwb_p1.valid;
    assign halt_hit = vld_p1 && memwb_p1.halt;

    // The instruction in WB leaves (retires) on any edge where it is not held by a stall;
    // a flush overrides a stall, so a stalled instruction still retires when flushed out.
    assign retire_en = vld_p1 && (flush || !stall);

    // Sticky halt: set once a valid HALT reaches WB, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else if (halt_hit) begin
            halt_q <= 1'b1;
        end
    end

    // Sticky error: set by a valid errored instruction in WB while not yet halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (vld_p1 && memwb_p1.err && !halt_q) begin
            err_q <= 1'b1;
        end
    end

    wb_retire_ctr #(
        .CNT_W (CNT_W)
    ) u_retire_ctr (
        .clk    (clk),
        .clr    (rst),
        .en     (retire_en),
        .freeze (halt_q),
        .count  (retired)
    );

    // The HALT instruction itself never writes, and nothing writes after halt.
    assign writeEn     = vld_p1 && memwb_p1.reg_wr && !memwb_p1.halt && !halt_q;
    assign writeRegSel = memwb_p1.wr_sel;
    assign writeData   = wb_select(memwb_p1.wb_src, memwb_p1.alu_res, memwb_p1.rd_data,
                                   memwb_p1.pc_inc, memwb_p1.imm);
    assign halt        = halt_q;
    assign err         = err_q;

`ifdef WB_FWD_EN
    // ---- WB -> forward boundary ----
    // Remember the write committed on the last non-stalled edge; dropped on reset or halt.
    always_ff @(posedge clk) begin
        if (rst || halt_q || halt_hit) begin
            fwd_valid <= 1'b0;
            fwd_sel   <= '0;
            fwd_data  <= '0;
        end else if (flush || !stall) begin
            fwd_valid <= writeEn;
            if (writeEn) begin
                fwd_sel  <= writeRegSel;
                fwd_data <= writeData;
            end
        end
    end
`endif

endmodule
